// File: rtl/float_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control and exception flags.
// Define FPMUL_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates and jams.
`timescale 1ns/1ps
module float_multiplier_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [3:0]             out_flags
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int DISC_W = PROD_W - MAN_W - 1;
    localparam int ESUM_W = EXP_W + 2;
    localparam logic signed [ESUM_W-1:0] BIAS   = ESUM_W'(2**(EXP_W-1) - 1);
    localparam logic signed [ESUM_W-1:0] E_MAX  = ESUM_W'(2**EXP_W - 1);
    localparam logic signed [ESUM_W-1:0] E_ZERO = '0;
    localparam logic [EXP_W-1:0]         EXP_ONES = '1;

    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

    logic                     en;
    logic                     sa, sb;
    logic [EXP_W-1:0]         ea, eb;
    logic [MAN_W-1:0]         fa, fb;
    logic                     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    kind_t                    kind_in;

    logic                     s1_valid, s1_sign;
    kind_t                    s1_kind;
    logic signed [ESUM_W-1:0] s1_esum;
    logic [SIG_W-1:0]         s1_ma, s1_mb;

    logic                     s2_valid, s2_sign;
    kind_t                    s2_kind;
    logic signed [ESUM_W-1:0] s2_esum;
    logic [PROD_W-1:0]        s2_prod;

    logic                     msb, inexact, carry;
    logic [PROD_W-2:0]        norm;
    logic [MAN_W-1:0]         frac_t, frac_r;
    logic signed [ESUM_W-1:0] e_fin;
    logic [W-1:0]             res_data;
    logic [3:0]               res_flags;
`ifdef FPMUL_ROUND_NEAREST_EN
    logic                     guard, rnd, sticky, round_up;
`endif

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign {sa, ea, fa} = in_a;
    assign {sb, eb, fb} = in_b;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);

    always_comb begin
        kind_in = K_NORM;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            kind_in = K_NAN;
        else if (a_inf || b_inf)
            kind_in = K_INF;
        else if (a_zero || b_zero)
            kind_in = K_ZERO;
    end

    // Normalise so the leading one sits just above the fraction field.
    assign msb     = s2_prod[PROD_W-1];
    assign norm    = msb ? s2_prod[PROD_W-2:0] : {s2_prod[PROD_W-3:0], 1'b0};
    assign frac_t  = norm[PROD_W-2 -: MAN_W];
    assign inexact = |norm[DISC_W-1:0];

`ifdef FPMUL_ROUND_NEAREST_EN
    assign guard    = norm[DISC_W-1];
    assign rnd      = norm[DISC_W-2];
    assign sticky   = |norm[DISC_W-3:0];
    assign round_up = guard && (rnd || sticky || frac_t[0]);
    assign {carry, frac_r} = {1'b0, frac_t} + (MAN_W+1)'(round_up);
`else
    assign carry  = 1'b0;
    assign frac_r = frac_t | MAN_W'(inexact);
`endif

    assign e_fin = s2_esum + ESUM_W'(msb) + ESUM_W'(carry);

    always_comb begin
        res_data  = '0;
        res_flags = '0;
        case (s2_kind)
            K_NAN: begin
                res_data  = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                res_flags = 4'b1000;
            end
            K_INF:  res_data = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            K_ZERO: res_data = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (e_fin >= E_MAX) begin
                    res_data  = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
                    res_flags = 4'b0101;
                end else if (e_fin <= E_ZERO) begin
                    res_data  = {s2_sign, {(W-1){1'b0}}};
                    res_flags = 4'b0011;
                end else begin
                    res_data  = {s2_sign, e_fin[EXP_W-1:0], frac_r};
                    res_flags = {3'b000, inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data  <= res_data;
                out_flags <= res_flags;
            end
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign <= sa ^ sb;
            s1_kind <= kind_in;
            s1_esum <= ESUM_W'(ea) + ESUM_W'(eb) - BIAS;
            s1_ma   <= {1'b1, fa};
            s1_mb   <= {1'b1, fb};
            s2_sign <= s1_sign;
            s2_kind <= s1_kind;
            s2_esum <= s1_esum;
            s2_prod <= PROD_W'(s1_ma) * PROD_W'(s1_mb);
        end
    end

endmodule

// File: tb/tb_float_multiplier_pipe.sv
// Scoreboard bench for float_multiplier_pipe: directed corner cases, a stall stream, a mid-stream
// reset and a randomized stream checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_float_multiplier_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_a, in_b, out_data;
    logic [3:0]   out_flags;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    bit rand_done = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;
    exp_t exp_q[$];

    float_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endfunction

    // Reference: value-level multiply of the significands with integer arithmetic.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        logic   s;
        int     ea, eb, e, sh;
        longint ma, mb, prod, q, rem, half;
        bit     za, zb, ia, ib, na, nb, inex;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        f  = 4'b0000;
        r  = 32'h0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
            return;
        end
        if (ia || ib) begin
            r = {s, 8'hFF, 23'h0};
            return;
        end
        if (za || zb) begin
            r = {s, 31'h0};
            return;
        end
        ma   = longint'(a[22:0]) + (longint'(1) << 23);
        mb   = longint'(b[22:0]) + (longint'(1) << 23);
        prod = ma * mb;
        e    = ea + eb - 127;
        if (prod >= (longint'(1) << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = prod >> sh;
        rem  = prod - (q << sh);
        inex = (rem != 0);
`ifdef FPMUL_ROUND_NEAREST_EN
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0]))
            q = q + 1;
        if (q >= (longint'(1) << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
`else
        half = 0;
        if (inex)
            q = q | 1;
`endif
        if (e >= 255) begin
            r = {s, 8'hFF, 23'h0};
            f = 4'b0101;
        end else if (e <= 0) begin
            r = {s, 31'h0};
            f = 4'b0011;
        end else begin
            r = {s, 8'(e), 23'(q)};
            f = {3'b000, inex};
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] fr;
        fr = 23'($urandom);
        case ($urandom_range(0, 11))
            0: e = 8'h00;
            1: begin e = 8'hFF; fr = '0; end
            2: begin e = 8'hFF; if (fr == 0) fr = 23'h1; end
            3: e = 8'($urandom_range(1, 4));
            4: e = 8'($urandom_range(250, 254));
            5: begin e = 8'($urandom_range(120, 135)); fr = '1; end
            6: e = 8'($urandom_range(55, 70));
            7: e = 8'($urandom_range(186, 200));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, fr};
    endfunction

    // Monitor: compares the presented result with the queue head every cycle it is valid,
    // so a stalled result must also hold its value; pops only on an actual transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("in_ready_en", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, want no valid result", out_data);
                end else begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_flags", out_flags, exp_q[0].flags);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                ref_mul(in_a, in_b, e.data, e.flags);
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int k;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("send_accepted", k < 1000, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        for (k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want_d, input logic [3:0] want_f);
        int lat;
        out_ready = 1'b1;
        send(a, b);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_data"}, out_data, want_d);
        check({name, "_flags"}, out_flags, want_f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] sa[8];
        logic [31:0] sb[8];
        int          out_base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_flags", out_flags, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        directed("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        directed("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        directed("underflow", 32'h80800000, 32'h00800000, 32'h80000000, 4'b0011);
        directed("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        directed("ninf_x_two", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        directed("nan_x_one", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        directed("nzero_x_two", 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
`ifdef FPMUL_ROUND_NEAREST_EN
        directed("round_all_ones", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);
`else
        directed("round_all_ones", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFF, 4'b0001);
`endif

        // Back-to-back stream with a five-cycle consumer stall in the middle.
        for (int i = 0; i < 8; i++) begin
            sa[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            sb[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
        end
        out_base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(sa[i], sb[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_out - out_base, 8);

        // Reset with three operations in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(sa[i], sb[i]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_flush_out_valid", out_valid, 0);
        repeat (6) begin @(posedge clk); #1; end
        directed("post_reset", 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);

        // Randomized stream with random backpressure and idle gaps.
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    send(rand_op(), rand_op());
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
